// File: rtl/morse_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : morse_sequencer_if
// Description : Push-side and playback-side signal bundle for morse_sequencer.
//               The master drives character entries and flush; the slave
//               (the sequencer) drives the mark outputs and FIFO status.
// Revision    : 1.0 - initial release
// ============================================================================
interface morse_sequencer_if #(
    parameter int DEPTH       = 8,
    parameter int MAX_SYMBOLS = 6
);
    localparam int c_len_w = $clog2(MAX_SYMBOLS + 1);
    localparam int c_cnt_w = $clog2(DEPTH) + 1;

    logic                   in_strb;
    logic                   in_space;
    logic [c_len_w-1:0]     in_len;
    logic [MAX_SYMBOLS-1:0] in_pattern;
    logic                   flush;
    logic                   dit_out;
    logic                   dah_out;
    logic                   morse_code_out;
    logic                   busy;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [c_cnt_w-1:0]     fifo_count;
    logic                   overflow;

    modport master (
        output in_strb, in_space, in_len, in_pattern, flush,
        input  dit_out, dah_out, morse_code_out, busy,
               fifo_full, fifo_empty, fifo_count, overflow
    );

    modport slave (
        input  in_strb, in_space, in_len, in_pattern, flush,
        output dit_out, dah_out, morse_code_out, busy,
               fifo_full, fifo_empty, fifo_count, overflow
    );
endinterface
`default_nettype wire

// File: rtl/morse_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : morse_sequencer
// Description : FIFO-buffered morse player. Entries are {space, len, pattern}
//               with pattern elements LSB first (0 = dit, 1 = dah). Unit
//               length, dah length and character/word gaps are programmable.
// Revision    : 1.0 - initial release
// ============================================================================
module morse_sequencer #(
    parameter int DEPTH          = 8,
    parameter int MAX_SYMBOLS    = 6,
    parameter int UNIT_CYCLES    = 600000,
    parameter int DAH_UNITS      = 3,
    parameter int CHAR_GAP_UNITS = 3,
    parameter int WORD_GAP_UNITS = 7
) (
    input  wire logic           clk,
    input  wire logic           rst,
    morse_sequencer_if.slave    bus
);
    localparam int c_len_w      = $clog2(MAX_SYMBOLS + 1);
    localparam int c_ptr_w      = $clog2(DEPTH);
    localparam int c_cnt_w      = c_ptr_w + 1;
    localparam int c_entry_w    = 1 + c_len_w + MAX_SYMBOLS;
    localparam int c_long_units = (DAH_UNITS > WORD_GAP_UNITS) ? DAH_UNITS : WORD_GAP_UNITS;
    localparam int c_tmr_w      = $clog2(c_long_units * UNIT_CYCLES + 1);

    localparam logic [c_tmr_w-1:0] c_dit_len  = c_tmr_w'(UNIT_CYCLES);
    localparam logic [c_tmr_w-1:0] c_dah_len  = c_tmr_w'(DAH_UNITS * UNIT_CYCLES);
    localparam logic [c_tmr_w-1:0] c_char_len = c_tmr_w'(CHAR_GAP_UNITS * UNIT_CYCLES);
    localparam logic [c_tmr_w-1:0] c_word_len = c_tmr_w'((WORD_GAP_UNITS - CHAR_GAP_UNITS) * UNIT_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_MARK     = 3'd1,
        S_ELEM_GAP = 3'd2,
        S_CHAR_GAP = 3'd3,
        S_WORD_GAP = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [c_tmr_w-1:0]     timer_q, timer_d;
    logic [MAX_SYMBOLS-1:0] shreg_q, shreg_d;
    logic [c_len_w-1:0]     elems_q, elems_d;
    logic [c_ptr_w-1:0]     wr_ptr_q, wr_ptr_d;
    logic [c_ptr_w-1:0]     rd_ptr_q, rd_ptr_d;
    logic [c_cnt_w-1:0]     count_q, count_d;
    logic                   overflow_q, overflow_d;
    logic                   dit_q, dit_d;
    logic                   dah_q, dah_d;
    logic [c_entry_w-1:0]   fifo_mem_q [DEPTH];

    logic                   w_full;
    logic                   w_empty;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_expire;
    logic [c_len_w-1:0]     w_wr_len;
    logic [c_entry_w-1:0]   w_head;
    logic                   w_head_space;
    logic [c_len_w-1:0]     w_head_len;
    logic [MAX_SYMBOLS-1:0] w_head_pat;

    // Fullness is judged on the pre-edge count; flush swallows any push or pop.
    assign w_full   = (count_q == c_cnt_w'(DEPTH));
    assign w_empty  = (count_q == '0);
    assign w_push   = bus.in_strb && !w_full && !bus.flush;
    assign w_pop    = (state_q == S_IDLE) && !w_empty && !bus.flush;
    assign w_expire = (timer_q == c_tmr_w'(1));
    assign w_wr_len = (bus.in_len > c_len_w'(MAX_SYMBOLS)) ? c_len_w'(MAX_SYMBOLS) : bus.in_len;

    assign w_head       = fifo_mem_q[rd_ptr_q];
    assign w_head_space = w_head[c_entry_w-1];
    assign w_head_len   = w_head[MAX_SYMBOLS +: c_len_w];
    assign w_head_pat   = w_head[MAX_SYMBOLS-1:0];

    // FIFO storage: written only on an accepted push, never reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            fifo_mem_q[wr_ptr_q] <= {bus.in_space, w_wr_len, bus.in_pattern};
        end
    end

    // FIFO pointer, occupancy and sticky overflow next-state.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (bus.flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            if (w_push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (bus.in_strb && w_full) begin
                overflow_d = 1'b1;
            end
            if (w_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Player next-state: the timer is reloaded on each state entry and the
    // state moves on when it reads 1. Marks are decoded from the next state
    // so they line up with the state register.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        shreg_d = shreg_q;
        elems_d = elems_q;
        case (state_q)
            S_IDLE: begin
                if (w_pop) begin
                    shreg_d = w_head_pat;
                    elems_d = w_head_len;
                    if (w_head_space) begin
                        state_d = S_WORD_GAP;
                        timer_d = c_word_len;
                    end else if (w_head_len != '0) begin
                        state_d = S_MARK;
                        timer_d = w_head_pat[0] ? c_dah_len : c_dit_len;
                    end
                end
            end
            S_MARK: begin
                if (w_expire) begin
                    if (elems_q > c_len_w'(1)) begin
                        state_d = S_ELEM_GAP;
                        timer_d = c_dit_len;
                        shreg_d = shreg_q >> 1;
                        elems_d = elems_q - 1'b1;
                    end else begin
                        state_d = S_CHAR_GAP;
                        timer_d = c_char_len;
                    end
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            S_ELEM_GAP: begin
                if (w_expire) begin
                    state_d = S_MARK;
                    timer_d = shreg_q[0] ? c_dah_len : c_dit_len;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            S_CHAR_GAP, S_WORD_GAP: begin
                if (w_expire) begin
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (bus.flush) begin
            state_d = S_IDLE;
        end
        dit_d = (state_d == S_MARK) && !shreg_d[0];
        dah_d = (state_d == S_MARK) &&  shreg_d[0];
    end

    // State, FIFO control and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            timer_q    <= '0;
            shreg_q    <= '0;
            elems_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            dit_q      <= 1'b0;
            dah_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            shreg_q    <= shreg_d;
            elems_q    <= elems_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            dit_q      <= dit_d;
            dah_q      <= dah_d;
        end
    end

    assign bus.dit_out        = dit_q;
    assign bus.dah_out        = dah_q;
    assign bus.morse_code_out = dit_q | dah_q;
    assign bus.busy           = (state_q != S_IDLE);
    assign bus.fifo_full      = w_full;
    assign bus.fifo_empty     = w_empty;
    assign bus.fifo_count     = count_q;
    assign bus.overflow       = overflow_q;
endmodule
`default_nettype wire

// File: tb/tb_morse_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_morse_sequencer
// Description : Self-checking bench for morse_sequencer. A queue-based model
//               expands each popped entry into its expected per-cycle
//               waveform; every cycle the DUT outputs are compared with it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_morse_sequencer;
    localparam int DEPTH = 8;
    localparam int MS    = 6;
    localparam int UNIT  = 4;
    localparam int DAH   = 3;
    localparam int CG    = 3;
    localparam int WG    = 7;
    localparam int LW    = $clog2(MS + 1);
    localparam int CNTW  = $clog2(DEPTH) + 1;

    typedef struct {
        bit          space;
        int          len;
        bit [MS-1:0] pat;
    } entry_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    morse_sequencer_if #(.DEPTH(DEPTH), .MAX_SYMBOLS(MS)) ifc ();

    morse_sequencer #(
        .DEPTH(DEPTH), .MAX_SYMBOLS(MS), .UNIT_CYCLES(UNIT),
        .DAH_UNITS(DAH), .CHAR_GAP_UNITS(CG), .WORD_GAP_UNITS(WG)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    // Model state: stored entries, pending waveform {busy,dit,dah} per cycle,
    // the currently displayed waveform value and the sticky overflow flag.
    entry_t   mq[$];
    bit [2:0] wq[$];
    bit [2:0] cur;
    bit       movf;

    int checks = 0;
    int passed = 0;
    int cycle  = 0;
    int dit_starts[$];
    bit prev_dit = 1'b0;

    task automatic gen(input entry_t e);
        if (e.space) begin
            repeat ((WG - CG) * UNIT) wq.push_back(3'b100);
        end else if (e.len > 0) begin
            for (int i = 0; i < e.len; i++) begin
                repeat (e.pat[i] ? DAH * UNIT : UNIT) wq.push_back(e.pat[i] ? 3'b101 : 3'b110);
                if (i < e.len - 1) repeat (UNIT) wq.push_back(3'b100);
            end
            repeat (CG * UNIT) wq.push_back(3'b100);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        wq.delete();
        cur  = 3'b000;
        movf = 1'b0;
    endtask

    task automatic model_edge(input bit s, input bit sp, input int l, input bit [MS-1:0] p, input bit f);
        bit     was_full;
        entry_t e;
        was_full = (mq.size() == DEPTH);
        if (f) begin
            model_reset();
            return;
        end
        if (!cur[2] && mq.size() > 0) begin
            e = mq.pop_front();
            gen(e);
        end
        if (s) begin
            if (was_full) begin
                movf = 1'b1;
            end else begin
                e.space = sp;
                e.len   = (l > MS) ? MS : l;
                e.pat   = p;
                mq.push_back(e);
            end
        end
        cur = (wq.size() > 0) ? wq.pop_front() : 3'b000;
    endtask

    task automatic check(input string tag);
        logic [CNTW+6:0] obs;
        logic [CNTW+6:0] exp;
        obs = {ifc.dit_out, ifc.dah_out, ifc.morse_code_out, ifc.busy,
               ifc.fifo_count, ifc.fifo_full, ifc.fifo_empty, ifc.overflow};
        exp = {cur[1], cur[0], cur[1] | cur[0], cur[2], CNTW'(mq.size()),
               mq.size() == DEPTH, mq.size() == 0, movf};
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cycle, obs, exp);
        if (ifc.dit_out === 1'b1 && !prev_dit) dit_starts.push_back(cycle);
        prev_dit = (ifc.dit_out === 1'b1);
    endtask

    task automatic cyc(input string tag, input bit s = 0, input bit sp = 0,
                       input int l = 0, input bit [MS-1:0] p = '0, input bit f = 0);
        ifc.in_strb    = s;
        ifc.in_space   = sp;
        ifc.in_len     = LW'(l);
        ifc.in_pattern = p;
        ifc.flush      = f;
        @(posedge clk);
        model_edge(s, sp, l, p, f);
        cycle++;
        @(negedge clk);
        check(tag);
    endtask

    initial begin
        int gap;
        ifc.in_strb    = 1'b0;
        ifc.in_space   = 1'b0;
        ifc.in_len     = '0;
        ifc.in_pattern = '0;
        ifc.flush      = 1'b0;
        model_reset();

        // Reset state.
        @(negedge clk);
        @(negedge clk);
        check("reset");
        rst = 1'b0;
        repeat (3) cyc("idle");

        // Letter A: dit then dah.
        cyc("t1_push", 1, 0, 2, 6'b000010);
        repeat (40) cyc("t1_play");

        // E, word space, E back to back: dit starts 34 cycles apart.
        dit_starts.delete();
        cyc("t2_e1", 1, 0, 1, 6'b000000);
        cyc("t2_sp", 1, 1, 0, 6'b000000);
        cyc("t2_e2", 1, 0, 1, 6'b000000);
        repeat (80) cyc("t2_play");
        gap = (dit_starts.size() == 2) ? dit_starts[1] - dit_starts[0] : -1;
        checks++;
        assert (gap === UNIT + CG * UNIT + 1 + (WG - CG) * UNIT + 1) passed++;
        else $error("FAIL t2_dit_spacing observed=%0d expected=%0d", gap, 34);

        // Stall on six dahs and push nine entries: the ninth overflows.
        cyc("t3_long", 1, 0, 6, 6'b111111);
        for (int i = 0; i < 9; i++) cyc("t3_fill", 1, 0, 2, 6'(i));
        repeat (2) cyc("t3_hold");
        checks++;
        assert ({ifc.overflow, ifc.fifo_full, ifc.fifo_count} === {1'b1, 1'b1, CNTW'(DEPTH)}) passed++;
        else $error("FAIL t3_overflow observed=%b/%b/%0d expected=1/1/%0d",
                    ifc.overflow, ifc.fifo_full, ifc.fifo_count, DEPTH);

        // Flush mid-dah together with a push.
        cyc("t4_flush", 1, 0, 3, 6'b000111, 1);
        checks++;
        assert ({ifc.morse_code_out, ifc.fifo_empty, ifc.overflow, ifc.busy} === 4'b0100) passed++;
        else $error("FAIL t4_after_flush observed=%b expected=0100",
                    {ifc.morse_code_out, ifc.fifo_empty, ifc.overflow, ifc.busy});
        repeat (20) cyc("t4_quiet");

        // Zero-length entry, then an over-long entry clamped to six dahs.
        cyc("t5_len0", 1, 0, 0, 6'b101010);
        cyc("t5_len7", 1, 0, 7, 6'b111111);
        repeat (6 * DAH * UNIT + 5 * UNIT + CG * UNIT + 6) cyc("t5_play");

        // Asynchronous reset mid-mark with three entries queued.
        cyc("t6_long", 1, 0, 6, 6'b111111);
        for (int i = 0; i < 3; i++) cyc("t6_fill", 1, 0, 1, 6'b000001);
        repeat (3) cyc("t6_mark");
        #2 rst = 1'b1;
        model_reset();
        #1 check("t6_async_rst");
        @(negedge clk);
        check("t6_rst_held");
        rst = 1'b0;
        repeat (30) cyc("t6_quiet");

        // Randomized traffic.
        for (int i = 0; i < 700; i++) begin
            bit s, sp, f;
            int l;
            bit [MS-1:0] p;
            s  = ($urandom_range(0, 5) == 0);
            sp = ($urandom_range(0, 5) == 0);
            l  = $urandom_range(0, 7);
            p  = MS'($urandom);
            f  = ($urandom_range(0, 200) == 0);
            cyc("rand", s, sp, l, p, f);
        end
        cyc("rand_flush", 0, 0, 0, '0, 1);
        repeat (5) cyc("final_idle");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
`default_nettype wire
